// File: rtl/stoch_signed_maxmin_n.sv
// N-input max/min selector for signed-channel (p, m) stochastic bitstreams.
// Per-input saturating estimators feed a hysteretic selector; the chosen channel is forwarded registered.
module stoch_signed_maxmin_n #(
    parameter int NUM_INPUTS   = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int HYSTERESIS   = 2,
    localparam int SEL_W       = $clog2(NUM_INPUTS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  en,
    input  logic                  mode,
    input  logic [NUM_INPUTS-1:0] x_p,
    input  logic [NUM_INPUTS-1:0] x_m,
    output logic                  y_p,
    output logic                  y_m,
    output logic [SEL_W-1:0]      sel
);

    localparam logic signed [COUNTER_SIZE-1:0] CNT_MAX = {1'b0, {(COUNTER_SIZE-1){1'b1}}};
    localparam logic signed [COUNTER_SIZE-1:0] CNT_MIN = {1'b1, {(COUNTER_SIZE-1){1'b0}}};
    localparam logic signed [COUNTER_SIZE+1:0] HYST    = (COUNTER_SIZE+2)'(HYSTERESIS);

    logic signed [COUNTER_SIZE-1:0] cnt_q [NUM_INPUTS];
    logic signed [COUNTER_SIZE:0]   score [NUM_INPUTS];
    logic signed [COUNTER_SIZE:0]   best_score;
    logic signed [COUNTER_SIZE:0]   sel_score;
    logic signed [COUNTER_SIZE+1:0] margin;
    logic [SEL_W-1:0]               best;
    logic                           mode_q;
    logic                           switch_sel;

    // One extra bit so negating the most negative count stays representable.
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (mode) begin
                score[i] = -{cnt_q[i][COUNTER_SIZE-1], cnt_q[i]};
            end else begin
                score[i] = {cnt_q[i][COUNTER_SIZE-1], cnt_q[i]};
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best       = '0;
        best_score = score[0];
        for (int i = 1; i < NUM_INPUTS; i++) begin
            if (score[i] > best_score) begin
                best       = SEL_W'(i);
                best_score = score[i];
            end
        end
        sel_score  = score[sel];
        margin     = {best_score[COUNTER_SIZE], best_score} - {sel_score[COUNTER_SIZE], sel_score};
        switch_sel = (mode != mode_q) || (margin > HYST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
            end
            sel    <= '0;
            mode_q <= 1'b0;
            y_p    <= 1'b0;
            y_m    <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (x_p[i] && !x_m[i] && cnt_q[i] != CNT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + COUNTER_SIZE'(1);
                end else if (x_m[i] && !x_p[i] && cnt_q[i] != CNT_MIN) begin
                    cnt_q[i] <= cnt_q[i] - COUNTER_SIZE'(1);
                end
            end
            if (switch_sel) begin
                sel <= best;
            end
            mode_q <= mode;
            y_p    <= x_p[sel];
            y_m    <= x_m[sel];
        end else begin
            y_p <= 1'b0;
            y_m <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stoch_signed_maxmin_n.sv
// Bench for stoch_signed_maxmin_n: reference model + scoreboard, vector table, directed corner cases.
module tb_stoch_signed_maxmin_n;

    localparam int N    = 4;
    localparam int CS   = 8;
    localparam int HYST = 2;

    logic         CLK;
    logic         RST;
    logic         en;
    logic         mode;
    logic [N-1:0] x_p;
    logic [N-1:0] x_m;
    logic         y_p;
    logic         y_m;
    logic [1:0]   sel;

    stoch_signed_maxmin_n #(
        .NUM_INPUTS  (N),
        .COUNTER_SIZE(CS),
        .HYSTERESIS  (HYST)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .en  (en),
        .mode(mode),
        .x_p (x_p),
        .x_m (x_m),
        .y_p (y_p),
        .y_m (y_m),
        .sel (sel)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cnt [N];
    int m_sel;
    bit m_mq;
    bit m_yp;
    bit m_ym;

    logic [3:0] sb [$];

    typedef struct {
        bit         en;
        bit         mode;
        logic [3:0] xp;
        logic [3:0] xm;
        int         exp_sel;
        bit         exp_yp;
        bit         exp_ym;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic model_edge(input bit rst, input bit e, input bit md,
                              input logic [3:0] xp, input logic [3:0] xm);
        int s [N];
        int b;
        int nsel;
        if (rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_sel = 0; m_mq = 0; m_yp = 0; m_ym = 0;
        end else if (e) begin
            for (int i = 0; i < N; i++) s[i] = md ? -m_cnt[i] : m_cnt[i];
            b = 0;
            for (int i = 1; i < N; i++) if (s[i] > s[b]) b = i;
            nsel = m_sel;
            if (md != m_mq) nsel = b;
            else if (s[b] - s[m_sel] > HYST) nsel = b;
            m_mq = md;
            m_yp = xp[m_sel];
            m_ym = xm[m_sel];
            for (int i = 0; i < N; i++) begin
                if (xp[i] && !xm[i] && m_cnt[i] < 127) m_cnt[i]++;
                else if (xm[i] && !xp[i] && m_cnt[i] > -128) m_cnt[i]--;
            end
            m_sel = nsel;
        end else begin
            m_yp = 0; m_ym = 0;
        end
    endtask

    task automatic step(input bit rst, input bit e, input bit md,
                        input logic [3:0] xp, input logic [3:0] xm);
        logic [3:0] want;
        RST = rst; en = e; mode = md; x_p = xp; x_m = xm;
        model_edge(rst, e, md, xp, xm);
        sb.push_back({m_yp, m_ym, 2'(m_sel)});
        @(posedge CLK);
        #1;
        want = sb.pop_front();
        check("outputs{yp,ym,sel}", int'({y_p, y_m, sel}), int'(want));
    endtask

    task automatic check_counters(input string name);
        for (int i = 0; i < N; i++) check(name, int'(dut.cnt_q[i]), m_cnt[i]);
    endtask

    initial begin
        tbl[0] = '{1, 0, 4'b0100, 4'b0000, 0, 0, 0};
        tbl[1] = '{1, 0, 4'b0100, 4'b0000, 0, 0, 0};
        tbl[2] = '{1, 0, 4'b0100, 4'b0000, 0, 0, 0};
        tbl[3] = '{1, 0, 4'b0100, 4'b0000, 2, 0, 0};
        tbl[4] = '{1, 0, 4'b0100, 4'b0000, 2, 1, 0};
        tbl[5] = '{1, 0, 4'b0100, 4'b0000, 2, 1, 0};
        tbl[6] = '{1, 1, 4'b0100, 4'b0000, 0, 1, 0};
        tbl[7] = '{1, 1, 4'b0100, 4'b0000, 0, 0, 0};
        tbl[8] = '{1, 1, 4'b0001, 4'b0000, 0, 1, 0};

        RST = 1; en = 0; mode = 0; x_p = 0; x_m = 0;

        // Reset with random inputs, random run, then reset mid-run
        step(1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        check("reset sel", int'(sel), 0);
        check("reset y", int'({y_p, y_m}), 0);
        for (int i = 0; i < N; i++) check("reset cnt", int'(dut.cnt_q[i]), 0);
        for (int k = 0; k < 50; k++)
            step(0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        check_counters("random cnt");
        step(1, 1, 1'($urandom), 4'($urandom), 4'($urandom));
        check("midrun reset sel", int'(sel), 0);
        check("midrun reset y", int'({y_p, y_m}), 0);
        for (int i = 0; i < N; i++) check("midrun reset cnt", int'(dut.cnt_q[i]), 0);

        // Max tracking then mode switch, from the vector table
        for (int k = 0; k < 9; k++) begin
            step(0, tbl[k].en, tbl[k].mode, tbl[k].xp, tbl[k].xm);
            check($sformatf("tbl[%0d] sel", k), int'(sel), tbl[k].exp_sel);
            check($sformatf("tbl[%0d] y_p", k), int'(y_p), int'(tbl[k].exp_yp));
            check($sformatf("tbl[%0d] y_m", k), int'(y_m), int'(tbl[k].exp_ym));
        end
        check("tbl C2", int'(dut.cnt_q[2]), 8);

        // Enable low freezes state and zeroes y; both-high holds counters
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1'($urandom), 4'($urandom), 4'($urandom));
            check("en0 y", int'({y_p, y_m}), 0);
        end
        check("en0 sel", int'(sel), 0);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 4'b1111, 4'b1111);
        check("tie C0", int'(dut.cnt_q[0]), 1);
        check("tie C2", int'(dut.cnt_q[2]), 8);
        check_counters("tie cnt");

        // Saturation at both ends, min-mode score +128
        step(1, 0, 0, 4'b0000, 4'b0000);
        for (int k = 0; k < 200; k++) step(0, 1, 0, 4'b0010, 4'b0000);
        check("sat C1", int'(dut.cnt_q[1]), 127);
        check("sat sel", int'(sel), 1);
        for (int k = 0; k < 200; k++) step(0, 1, 0, 4'b0000, 4'b1000);
        check("sat C3", int'(dut.cnt_q[3]), -128);
        check("sat C1 hold", int'(dut.cnt_q[1]), 127);
        step(0, 1, 1, 4'b0000, 4'b0000);
        check("min sat sel", int'(sel), 3);
        step(0, 1, 1, 4'b0000, 4'b1000);
        check("min sat sel hold", int'(sel), 3);

        // Hysteresis hold and release
        step(1, 0, 0, 4'b0000, 4'b0000);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 4'b0100, 4'b0000);
        check("hyst C2", int'(dut.cnt_q[2]), 10);
        check("hyst sel2", int'(sel), 2);
        for (int k = 0; k < 13; k++) step(0, 1, 0, 4'b0001, 4'b0000);
        check("hyst C0", int'(dut.cnt_q[0]), 13);
        check("hyst hold", int'(sel), 2);
        step(0, 1, 0, 4'b0001, 4'b0000);
        check("hyst switch", int'(sel), 0);
        step(0, 1, 0, 4'b0001, 4'b0000);
        check("hyst follow y_p", int'(y_p), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
